// File: rtl/disparity_filter_sequencer_pkg.sv
// Shared types and helpers for the disparity filter sequencer.
package filter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

  // Number of pixels in one frame, i.e. filter outputs expected per frame.
  function automatic int frame_pixels(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/disparity_filter_sequencer_line_position_counter.sv
// Column/row position tracker with line and frame boundary flags.
module line_position_counter
  import filter_pkg::*;
#(
  parameter int frame_width  = 640,
  parameter int frame_height = 480
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic first_pixel,
  output logic last_pixel,
  output logic frame_last
);

  localparam int XW = (frame_width  > 1) ? $clog2(frame_width)  : 1;
  localparam int YW = (frame_height > 1) ? $clog2(frame_height) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // x wraps at end of line and carries into y; the caller never advances past the frame-last pixel
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_pixel) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign first_pixel = (x == '0);
  assign last_pixel  = (x == XW'(frame_width - 1));
  assign frame_last  = last_pixel && (y == YW'(frame_height - 1));

endmodule

// File: rtl/disparity_filter_sequencer.sv
// Frame sequencer: numbers incoming pixels, forwards them with position flags
// to the bilateral filter, then waits for the filter to drain the frame.
module disparity_filter_sequencer
  import filter_pkg::*;
#(
  parameter int disp_bits     = 5,
  parameter int frame_width   = 640,
  parameter int frame_height  = 480,
  parameter int drain_timeout = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pix_valid_in,
  input  logic [disp_bits-1:0] disparity_in,
  input  logic [7:0]           confidence_in,
  input  logic [7:0]           gray_in,
  output logic [disp_bits-1:0] filt_disparity,
  output logic [7:0]           filt_confidence,
  output logic [7:0]           filt_gray,
  output logic                 filt_first_pixel_in_line,
  output logic                 filt_last_pixel_in_line,
  output logic                 filt_last_pixel_in_frame,
  output logic                 filt_in_valid,
  input  logic                 filt_out_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun_err,
  output logic                 timeout_err
);

  localparam int NPIX = frame_pixels(frame_width, frame_height);
  localparam int CW   = $clog2(NPIX + 1);
  localparam int TW   = $clog2(drain_timeout + 1);
  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
  localparam logic [TW-1:0] TMO_C  = TW'(drain_timeout);

  seq_state_t    state;
  logic [CW-1:0] out_count;
  logic [TW-1:0] timer;
  logic [CW-1:0] count_inc;
  logic [TW-1:0] timer_inc;
  logic          pos_first, pos_last, pos_frame_last;
  logic          accept;

  assign accept    = (state == RUN) && pix_valid_in;
  assign count_inc = (out_count == NPIX_C) ? out_count : out_count + 1'b1;
  assign timer_inc = (timer == TMO_C) ? timer : timer + 1'b1;
  assign busy      = (state == RUN) || (state == DRAIN);

  line_position_counter #(
    .frame_width (frame_width),
    .frame_height(frame_height)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .clear      ((state == IDLE) && start),
    .advance    (accept && !pos_frame_last),
    .first_pixel(pos_first),
    .last_pixel (pos_last),
    .frame_last (pos_frame_last)
  );

  // Frame FSM with registered forwarding, output counting and drain watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= IDLE;
      out_count                <= '0;
      timer                    <= '0;
      filt_disparity           <= '0;
      filt_confidence          <= '0;
      filt_gray                <= '0;
      filt_first_pixel_in_line <= 1'b0;
      filt_last_pixel_in_line  <= 1'b0;
      filt_last_pixel_in_frame <= 1'b0;
      filt_in_valid            <= 1'b0;
      frame_done               <= 1'b0;
      overrun_err              <= 1'b0;
      timeout_err              <= 1'b0;
    end else begin
      filt_in_valid <= 1'b0;
      frame_done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            out_count   <= '0;
            timer       <= '0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        RUN: begin
          if (pix_valid_in) begin
            filt_disparity           <= disparity_in;
            filt_confidence          <= confidence_in;
            filt_gray                <= gray_in;
            filt_first_pixel_in_line <= pos_first;
            filt_last_pixel_in_line  <= pos_last;
            filt_last_pixel_in_frame <= pos_frame_last;
            filt_in_valid            <= 1'b1;
            if (pos_frame_last) state <= DRAIN;
          end
          if (filt_out_valid) out_count <= count_inc;
        end
        DRAIN: begin
          if (pix_valid_in) overrun_err <= 1'b1;
          if (filt_out_valid) begin
            out_count <= count_inc;
            timer     <= '0;
          end else begin
            timer <= timer_inc;
          end
          // a completed count takes priority over a simultaneous timeout
          if (filt_out_valid && (count_inc == NPIX_C)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else if (!filt_out_valid && (timer_inc == TMO_C)) begin
            timeout_err <= 1'b1;
            state       <= DONE;
            frame_done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_filter_sequencer.sv
// Self-checking bench: random data and gaps against a frame-bookkeeping model.
module tb_disparity_filter_sequencer;

  localparam int D = 5;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         pix_valid_in = 1'b0;
  logic [D-1:0] disparity_in = '0;
  logic [7:0]   confidence_in = '0;
  logic [7:0]   gray_in = '0;
  logic         filt_out_valid = 1'b0;
  logic [D-1:0] filt_disparity;
  logic [7:0]   filt_confidence, filt_gray;
  logic         filt_first_pixel_in_line, filt_last_pixel_in_line, filt_last_pixel_in_frame;
  logic         filt_in_valid, busy, frame_done, overrun_err, timeout_err;

  disparity_filter_sequencer #(
    .disp_bits(D), .frame_width(W), .frame_height(H), .drain_timeout(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid_in(pix_valid_in),
    .disparity_in(disparity_in), .confidence_in(confidence_in), .gray_in(gray_in),
    .filt_disparity(filt_disparity), .filt_confidence(filt_confidence), .filt_gray(filt_gray),
    .filt_first_pixel_in_line(filt_first_pixel_in_line),
    .filt_last_pixel_in_line(filt_last_pixel_in_line),
    .filt_last_pixel_in_frame(filt_last_pixel_in_frame),
    .filt_in_valid(filt_in_valid), .filt_out_valid(filt_out_valid),
    .busy(busy), .frame_done(frame_done), .overrun_err(overrun_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: frame phase flags, pixel/output tallies, expected forwarded pixel
  bit         m_run, m_drain, m_done, m_valid, m_ovr, m_tmo;
  int         m_taken, m_outs, m_gap;
  logic [D-1:0] m_disp;
  logic [7:0] m_conf, m_gray;
  bit         m_first, m_last, m_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_valid",   32'(filt_in_valid),            32'(m_valid));
    chk("busy",       32'(busy),                     32'(m_run || m_drain));
    chk("frame_done", 32'(frame_done),               32'(m_done));
    chk("overrun",    32'(overrun_err),              32'(m_ovr));
    chk("timeout",    32'(timeout_err),              32'(m_tmo));
    chk("disparity",  32'(filt_disparity),           32'(m_disp));
    chk("confidence", 32'(filt_confidence),          32'(m_conf));
    chk("gray",       32'(filt_gray),                32'(m_gray));
    chk("first",      32'(filt_first_pixel_in_line), 32'(m_first));
    chk("last",       32'(filt_last_pixel_in_line),  32'(m_last));
    chk("frame_last", 32'(filt_last_pixel_in_frame), 32'(m_fl));
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pix_valid_in = 1'b0; filt_out_valid = 1'b0;
    @(posedge clk); #1;
    {m_run, m_drain, m_done, m_valid, m_ovr, m_tmo} = '0;
    m_taken = 0; m_outs = 0; m_gap = 0;
    m_disp = '0; m_conf = '0; m_gray = '0;
    {m_first, m_last, m_fl} = '0;
    check_all();
    reset = 1'b0;
  endtask

  task automatic cycle(input bit s, input bit pv, input bit ov);
    start = s; pix_valid_in = pv; filt_out_valid = ov;
    disparity_in = D'($urandom); confidence_in = 8'($urandom); gray_in = 8'($urandom);
    m_valid = 1'b0;
    if (m_done) begin
      m_done = 1'b0;                      // completion cycle: start ignored
    end else if (m_run) begin
      if (pv) begin
        m_valid = 1'b1;
        m_disp = disparity_in; m_conf = confidence_in; m_gray = gray_in;
        m_first = (m_taken % W) == 0;
        m_last  = (m_taken % W) == W - 1;
        m_fl    = (m_taken == N - 1);
        m_taken++;
        if (m_taken == N) begin m_run = 1'b0; m_drain = 1'b1; end
      end
      if (ov && m_outs < N) m_outs++;
    end else if (m_drain) begin
      if (pv) m_ovr = 1'b1;
      if (ov) begin
        if (m_outs < N) m_outs++;
        m_gap = 0;
        if (m_outs == N) begin m_drain = 1'b0; m_done = 1'b1; end
      end else begin
        m_gap++;
        if (m_gap == T) begin m_tmo = 1'b1; m_drain = 1'b0; m_done = 1'b1; end
      end
    end else if (s) begin
      m_run = 1'b1; m_taken = 0; m_outs = 0; m_gap = 0; m_ovr = 1'b0; m_tmo = 1'b0;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction

  initial begin
    do_reset();

    // pixels while idle are dropped and do not advance position
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    // back-to-back frame, drain with short gaps, start during completion ignored
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (i % 3 == 0) cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // gapped input (every 3rd cycle), then an overrun pixel during drain
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) cycle(1'b0, coin(), 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // next start clears overrun; frame with only 6 outputs times out
    cycle(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 64 && m_run; c++) cycle(1'b0, coin(), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
    repeat (T + 4) cycle(1'b0, 1'b0, 1'b0);

    // reset mid-frame after 3 pixels, then a random frame from scratch
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 80; c++) cycle(1'b0, coin(), m_drain ? coin() : 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
